// File: rtl/desc_rsqrt_gen_pkg.sv
// Shared constants, FSM state type and lane helper for desc_rsqrt_gen.
// Imported by the top and by the iterative square-root sub-module.
package desc_rsqrt_gen_pkg;

    localparam int LANES   = 8;
    localparam int LANE_W  = 8;
    localparam int DATA_W  = LANES * LANE_W;
    localparam int ACC_W   = 32;
    localparam int ROOT_W  = ACC_W / 2;
    localparam int RSQ_W   = 24;
    localparam int DIV_CW  = $clog2(RSQ_W);
    // 8 lanes of (-128)^2 sum to 2^17, so one beat needs 18 bits.
    localparam int SQ_W    = 18;

    localparam logic [RSQ_W-1:0] RSQ_NUM = 24'd65024;

    typedef enum logic [1:0] {
        ACC,
        SQRT,
        DIV,
        OUT
    } state_e;

    // Sum of squares of the signed int8 lanes of one beat.
    function automatic logic [SQ_W-1:0] lane_sq_sum(
        input logic [DATA_W-1:0] d
    );
        int s;
        int v;
        s = 0;
        for (int i = 0; i < LANES; i++) begin
            v = int'($signed(d[i*LANE_W +: LANE_W]));
            s = s + v * v;
        end
        return s[SQ_W-1:0];
    endfunction

endpackage

// File: rtl/desc_rsqrt_gen_isqrt.sv
// Start/done iterative integer square root, one root bit per cycle.
// Ports: clk, rst, start_i, radicand_i -> done_o (1-cycle pulse), root_o.
module desc_rsqrt_gen_isqrt
    import desc_rsqrt_gen_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [ACC_W-1:0]  radicand_i,
    output logic              done_o,
    output logic [ROOT_W-1:0] root_o
);

    localparam int CW = $clog2(ROOT_W);

    logic [ACC_W-1:0]  x_q, x_d;
    logic [ROOT_W+1:0] rem_q, rem_d;
    logic [ROOT_W-1:0] root_q, root_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              run_q, run_d;
    logic              done_q, done_d;

    logic [ROOT_W+3:0] rem_t;
    logic [ROOT_W+3:0] trial;
    logic [ROOT_W+3:0] diff;
    logic              ge;

    always_comb begin
        rem_t  = {rem_q, x_q[ACC_W-1 -: 2]};
        trial  = {2'b00, root_q, 2'b01};
        diff   = rem_t - trial;
        ge     = (rem_t >= trial);
        x_d    = x_q;
        rem_d  = rem_q;
        root_d = root_q;
        cnt_d  = cnt_q;
        run_d  = run_q;
        done_d = 1'b0;
        if (start_i) begin
            x_d    = radicand_i;
            rem_d  = '0;
            root_d = '0;
            cnt_d  = '0;
            run_d  = 1'b1;
        end else if (run_q) begin
            x_d   = {x_q[ACC_W-3:0], 2'b00};
            cnt_d = cnt_q + 1'b1;
            if (ge) begin
                rem_d  = diff[ROOT_W+1:0];
                root_d = {root_q[ROOT_W-2:0], 1'b1};
            end else begin
                // rem_t < trial here, so it fits the stored width.
                rem_d  = rem_t[ROOT_W+1:0];
                root_d = {root_q[ROOT_W-2:0], 1'b0};
            end
            if (cnt_q == CW'(ROOT_W - 1)) begin
                run_d  = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q    <= '0;
            rem_q  <= '0;
            root_q <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            x_q    <= x_d;
            rem_q  <= rem_d;
            root_q <= root_d;
            cnt_q  <= cnt_d;
            run_q  <= run_d;
            done_q <= done_d;
        end
    end

    assign done_o = done_q;
    assign root_o = root_q;

endmodule

// File: rtl/desc_rsqrt_gen.sv
// Reciprocal-sqrt scale generator: sum of squares -> isqrt -> 65024/r.
// Ports: clk, rst, s_axis_raw_* (int8 x8 beats in), m_axis_rsq_* (scale out), busy.
module desc_rsqrt_gen
    import desc_rsqrt_gen_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] s_axis_raw_tdata,
    input  logic              s_axis_raw_tvalid,
    input  logic              s_axis_raw_tlast,
    output logic              s_axis_raw_tready,
    output logic [RSQ_W-1:0]  m_axis_rsq_tdata,
    output logic              m_axis_rsq_tvalid,
    input  logic              m_axis_rsq_tready,
    output logic              busy
);

    state_e state_q, state_d;

    logic [ACC_W-1:0]  acc_q, acc_d;
    logic              in_desc_q, in_desc_d;
    logic [ROOT_W-1:0] r_q, r_d;
    logic [RSQ_W-1:0]  num_q, num_d;
    logic [ROOT_W-1:0] drem_q, drem_d;
    logic [DIV_CW-1:0] dcnt_q, dcnt_d;
    logic [RSQ_W-1:0]  q_q, q_d;

    logic [ACC_W-1:0]  acc_sum;
    logic              sq_start;
    logic              sq_done;
    logic [ROOT_W-1:0] sq_root;

    logic [ROOT_W:0]   drem_t;
    logic [ROOT_W:0]   dsub;
    logic              dge;

    desc_rsqrt_gen_isqrt u_isqrt (
        .clk        (clk),
        .rst        (rst),
        .start_i    (sq_start),
        .radicand_i (acc_sum),
        .done_o     (sq_done),
        .root_o     (sq_root)
    );

    assign acc_sum = acc_q + ACC_W'(lane_sq_sum(s_axis_raw_tdata));

    always_comb begin
        drem_t    = {drem_q, num_q[RSQ_W-1]};
        dsub      = drem_t - {1'b0, r_q};
        dge       = (drem_t >= {1'b0, r_q});
        state_d   = state_q;
        acc_d     = acc_q;
        in_desc_d = in_desc_q;
        r_d       = r_q;
        num_d     = num_q;
        drem_d    = drem_q;
        dcnt_d    = dcnt_q;
        q_d       = q_q;
        sq_start  = 1'b0;
        unique case (state_q)
            ACC: begin
                if (s_axis_raw_tvalid) begin
                    if (s_axis_raw_tlast) begin
                        sq_start  = 1'b1;
                        acc_d     = '0;
                        in_desc_d = 1'b0;
                        state_d   = SQRT;
                    end else begin
                        acc_d     = acc_sum;
                        in_desc_d = 1'b1;
                    end
                end
            end
            SQRT: begin
                if (sq_done) begin
                    r_d    = sq_root;
                    num_d  = RSQ_NUM;
                    drem_d = '0;
                    dcnt_d = '0;
                    q_d    = '0;
                    // Zero descriptor: no divide, scale is 0.
                    state_d = (sq_root == '0) ? OUT : DIV;
                end
            end
            DIV: begin
                num_d  = {num_q[RSQ_W-2:0], 1'b0};
                q_d    = {q_q[RSQ_W-2:0], dge};
                drem_d = dge ? dsub[ROOT_W-1:0] : drem_t[ROOT_W-1:0];
                dcnt_d = dcnt_q + 1'b1;
                if (dcnt_q == DIV_CW'(RSQ_W - 1)) begin
                    state_d = OUT;
                end
            end
            OUT: begin
                if (m_axis_rsq_tready) begin
                    state_d = ACC;
                end
            end
            default: state_d = ACC;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ACC;
            acc_q     <= '0;
            in_desc_q <= 1'b0;
            r_q       <= '0;
            num_q     <= '0;
            drem_q    <= '0;
            dcnt_q    <= '0;
            q_q       <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            in_desc_q <= in_desc_d;
            r_q       <= r_d;
            num_q     <= num_d;
            drem_q    <= drem_d;
            dcnt_q    <= dcnt_d;
            q_q       <= q_d;
        end
    end

    assign s_axis_raw_tready = (state_q == ACC);
    assign m_axis_rsq_tvalid = (state_q == OUT);
    assign m_axis_rsq_tdata  = q_q;
    assign busy              = (state_q != ACC) || in_desc_q;

endmodule
